// File: rtl/bottle_capper.sv
// -----------------------------------------------------------------------------
// bottle_capper
//
// Capping station that sits directly after the filler. The block:
//   - counts filled bottles in transit from the filler exit to the capper,
//   - clamps each bottle when it reaches the capping head,
//   - screws a cap on and waits for the chuck to report torque,
//   - then releases the bottle, or diverts it through the reject gate.
// It holds the filler back while the transit queue is full or an alarm is active.
//
// Build option:
//   CAPPER_STATS_EN  When defined, 16-bit wrapping good/reject counters are built.
//                    When it is not defined, both count ports are tied to zero.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   bottle_in_i      1-cycle pulse: a filled bottle left the filler
//   cap_sensor_i     level: a bottle is under the capping head
//   cap_available_i  level: the cap feeder has a cap staged
//   torque_ok_i      level: the chuck reached target torque
//   estop_i          level: emergency stop
//   fault_clear_i    1-cycle pulse: the operator acknowledges a fault
//   conveyor_on_o    capper conveyor motor
//   clamp_on_o       bottle clamp
//   chuck_spin_o     capping chuck motor
//   reject_gate_o    reject diverter
//   alarm_o          an ESTOP or FAULT is active
//   upstream_hold_o  the filler must not release another bottle
//   queue_count_o    number of bottles in transit
//   good_count_o     number of capped bottles
//   reject_count_o   number of rejected bottles
// -----------------------------------------------------------------------------
module bottle_capper #(
    parameter int CLAMP_CYCLES   = 3,
    parameter int TORQUE_TIMEOUT = 10,
    parameter int REJECT_CYCLES  = 4,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bottle_in_i,
    input  logic        cap_sensor_i,
    input  logic        cap_available_i,
    input  logic        torque_ok_i,
    input  logic        estop_i,
    input  logic        fault_clear_i,
    output logic        conveyor_on_o,
    output logic        clamp_on_o,
    output logic        chuck_spin_o,
    output logic        reject_gate_o,
    output logic        alarm_o,
    output logic        upstream_hold_o,
    output logic [2:0]  queue_count_o,
    output logic [15:0] good_count_o,
    output logic [15:0] reject_count_o
);

    // The timer never has to hold more than the longest dwell minus one.
    localparam int TMAX    = (CLAMP_CYCLES > TORQUE_TIMEOUT) ?
                             ((CLAMP_CYCLES > REJECT_CYCLES) ? CLAMP_CYCLES : REJECT_CYCLES) :
                             ((TORQUE_TIMEOUT > REJECT_CYCLES) ? TORQUE_TIMEOUT : REJECT_CYCLES);
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TIMER_W-1:0] CLAMP_LAST  = TIMER_W'(CLAMP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TWIST_LAST  = TIMER_W'(TORQUE_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] REJECT_LAST = TIMER_W'(REJECT_CYCLES - 1);
    localparam logic [2:0]         DEPTH       = 3'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_CLAMP, S_TWIST, S_RELEASE, S_REJECT, S_FAULT, S_ESTOP
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         count_q, count_d;
    logic               full;
    logic               take;
    logic               overflow;

    assign full = (count_q == DEPTH);
    // A bottle leaves the queue only on the WAIT->CLAMP transition, which estop blocks.
    assign take = (state_q == S_WAIT) && cap_sensor_i && (count_q != 3'd0) && !estop_i;
    // An arrival into a full queue is a fault, unless a bottle leaves in the same cycle.
    assign overflow = bottle_in_i && full && !take;

    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (estop_i) begin
            state_d = S_ESTOP;
        end else if (overflow) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE:    state_d = S_WAIT;
                S_WAIT:    if (take) state_d = S_CLAMP;
                S_CLAMP:   if (timer_q == CLAMP_LAST)
                               state_d = cap_available_i ? S_TWIST : S_REJECT;
                S_TWIST:   if (torque_ok_i)                state_d = S_RELEASE;
                           else if (timer_q == TWIST_LAST) state_d = S_REJECT;
                S_RELEASE: state_d = S_WAIT;
                S_REJECT:  if (timer_q == REJECT_LAST) state_d = S_WAIT;
                S_FAULT:   if (fault_clear_i) state_d = S_WAIT;
                S_ESTOP:   state_d = S_FAULT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (bottle_in_i && !take && !full) begin
            count_d = count_q + 3'd1;
        end else if (take && !bottle_in_i) begin
            count_d = count_q - 3'd1;
        end
    end

    // The timer restarts on any state change, so it reads "cycles already spent here".
    always_comb begin
        timer_d = '0;
        if (state_d == state_q &&
            (state_q == S_CLAMP || state_q == S_TWIST || state_q == S_REJECT)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // Moore output decode.
    always_comb begin
        conveyor_on_o = 1'b0;
        clamp_on_o    = 1'b0;
        chuck_spin_o  = 1'b0;
        reject_gate_o = 1'b0;
        alarm_o       = 1'b0;
        unique case (state_q)
            S_WAIT:   conveyor_on_o = (count_q != 3'd0);
            S_CLAMP:  clamp_on_o    = 1'b1;
            S_TWIST: begin
                clamp_on_o   = 1'b1;
                chuck_spin_o = 1'b1;
            end
            S_REJECT: begin
                conveyor_on_o = 1'b1;
                reject_gate_o = 1'b1;
            end
            S_FAULT, S_ESTOP: alarm_o = 1'b1;
            default: ;
        endcase
    end

    assign upstream_hold_o = full | alarm_o;
    assign queue_count_o   = count_q;

`ifdef CAPPER_STATS_EN
    logic [15:0] good_q;
    logic [15:0] reject_q;

    // The counters update on entry only. An estop that aborts a bottle is therefore never counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_q   <= '0;
            reject_q <= '0;
        end else begin
            if (state_d == S_RELEASE && state_q != S_RELEASE) good_q   <= good_q + 16'd1;
            if (state_d == S_REJECT  && state_q != S_REJECT)  reject_q <= reject_q + 16'd1;
        end
    end

    assign good_count_o   = good_q;
    assign reject_count_o = reject_q;
`else
    assign good_count_o   = 16'd0;
    assign reject_count_o = 16'd0;
`endif

endmodule
